fetcher: RTL and testbench
==========================

// Module: fetcher
// PURPOSE
//  Front-end PC sequencer directly upstream of the instruction cache. Presents fet_pc to the
//  icache, consumes each hit (16- or 32-bit RVC-aware instruction) and pushes it into the
//  instruction queue. Computes the next PC with static prediction: JAL always taken, branches
//  backward-taken/forward-not-taken, JALR stops fetch until the backend redirects.
// PARAMETERS
//  RESET_PC   32'h0   PC loaded on reset
// PORTS
//  clk                input   1   clock, all state updates on posedge
//  rst_n              input   1   asynchronous, active-low reset
//  flush              input   1   backend redirect (mispredict/JALR resolve)
//  flush_pc           input   32  redirect target, valid when flush=1
//  stall              input   1   global stall; freezes PC and state
//  iq_full            input   1   instruction queue cannot accept a push this cycle
//  icache_ready       input   1   icache hit for fet_pc (combinational in icache)
//  icache_inst        input   32  hit instruction; upper 16 bits are 0 for RVC
//  fet_icache_enable  output  1   request lookup of fet_pc (combinational)
//  fet_pc             output  32  current fetch PC (register)
//  fet_iq_enable      output  1   one-cycle push strobe to the IQ (register)
//  fet_iq_inst        output  32  pushed instruction (register)
//  fet_iq_pc          output  32  PC of pushed instruction (register)
//  fet_iq_is_c        output  1   pushed instruction is 16-bit (register)
//  fet_iq_pred_pc     output  32  predicted next PC (register)
// BEHAVIOUR
//  Reset (rst_n=0, async): fet_pc=RESET_PC, state=FETCH, all fet_iq_* outputs 0.
//  States: FETCH, WAIT_REDIRECT.
//  fet_icache_enable = (state==FETCH) && !iq_full && !flush.
//  accept = fet_icache_enable && icache_ready && !stall. Priority each posedge: flush > stall > accept.
//  flush: fet_pc<=flush_pc, state<=FETCH, fet_iq_enable<=0 (in-flight accept dropped).
//  stall (no flush): fet_pc and state hold; fet_iq_enable<=0.
//  accept: fet_iq_enable<=1, fet_iq_inst/pc/is_c/pred_pc<=current values; fet_pc<=pred_pc.
//   is_c = (inst[1:0]!=2'b11); seq = fet_pc + (is_c ? 2 : 4); all adds mod 2^32.
//   pred_pc by decode (imm sign-extended, bit0=0):
//    JAL (opc 1101111): fet_pc + {i[31],i[19:12],i[20],i[30:21],0}.
//    BRANCH (opc 1100011): i[31]=1 -> fet_pc + {i[31],i[7],i[30:25],i[11:8],0}; else seq.
//    C.J / C.JAL (q01, f3 101/001): fet_pc + {i[12],i[8],i[10:9],i[6],i[7],i[2],i[11],i[5:3],0}.
//    C.BEQZ/C.BNEZ (q01, f3 110/111): i[12]=1 -> fet_pc + {i[12],i[6:5],i[2],i[11:10],i[4:3],0}; else seq.
//    JALR (opc 1100111) or C.JR/C.JALR (q10, f3 100, i[11:7]!=0, i[6:2]==0): pred_pc=seq,
//     state<=WAIT_REDIRECT.
//    anything else: seq.
//  no accept (miss or iq_full): fet_pc holds, fet_iq_enable<=0.
//  WAIT_REDIRECT: no lookups; exits only via flush (then fetch resumes at flush_pc next cycle).
//  fet_iq_enable is never high two cycles for the same instruction; one push per accept.
//  rst_n deassert mid-operation: first lookup of RESET_PC is the cycle after release.
//  fet_pc may be halfword-aligned; no alignment checks performed.
// TESTING
//  T1 reset, icache_ready=1 with 32'h00100093 at 0 -> push pc=0,is_c=0,pred=4; next fet_pc=4.
//  T2 RVC 32'h00000505 at 4 -> push is_c=1,pred=6; fet_pc=6; then 32-bit at 6 -> fet_pc=10.
//  T3 JAL 32'h0200006F at 0x10 -> pred_pc=0x30, fet_pc=0x30; BEQ imm -8 at 0x40 -> fet_pc=0x38;
//     BEQ imm +8 at 0x40 -> fet_pc=0x44.
//  T4 JALR 32'h00008067 at 0x50 -> push, state WAIT, fet_icache_enable=0 for 10 cycles;
//     flush with flush_pc=0x100 -> next cycle fet_pc=0x100, enable=1.
//  T5 iq_full=1 or stall=1 with icache_ready=1 -> no push, fet_pc unchanged; release -> one push.
//  T6 flush and accept same edge -> fet_pc=flush_pc, fet_iq_enable=0; rst_n low mid-run ->
//     outputs to reset values immediately (async).

Source files
------------

// File: rtl/fetcher_if.sv
// Fetch-stage bus: backend control, icache hit path and instruction-queue push.
interface fetcher_if;
  logic        flush;
  logic [31:0] flush_pc;
  logic        stall;
  logic        iq_full;
  logic        icache_ready;
  logic [31:0] icache_inst;
  logic        fet_icache_enable;
  logic [31:0] fet_pc;
  logic        fet_iq_enable;
  logic [31:0] fet_iq_inst;
  logic [31:0] fet_iq_pc;
  logic        fet_iq_is_c;
  logic [31:0] fet_iq_pred_pc;

  modport master (
    input  flush, flush_pc, stall, iq_full, icache_ready, icache_inst,
    output fet_icache_enable, fet_pc, fet_iq_enable, fet_iq_inst, fet_iq_pc,
           fet_iq_is_c, fet_iq_pred_pc
  );

  modport slave (
    output flush, flush_pc, stall, iq_full, icache_ready, icache_inst,
    input  fet_icache_enable, fet_pc, fet_iq_enable, fet_iq_inst, fet_iq_pc,
           fet_iq_is_c, fet_iq_pred_pc
  );
endinterface

// File: rtl/fetcher.sv
// RVC-aware PC sequencer in front of the icache with static next-PC prediction.
module fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic clk,
  input  logic rst_n,
  fetcher_if.master bus
);
  typedef enum logic {FETCH = 1'b0, WAIT_REDIRECT = 1'b1} state_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_c;
    logic [31:0] pred_pc;
  } iq_push_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  iq_push_t    push_q, push_d;

  logic [31:0] inst, seq_pc, pred_pc;
  logic [31:0] imm_j, imm_b, imm_cj, imm_cb;
  logic        is_c, stop, accept;

  assign inst   = bus.icache_inst;
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_cj = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                   inst[2], inst[11], inst[5:3], 1'b0};
  assign imm_cb = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};

  // Static prediction: jumps taken, backward branches taken, indirect jumps park fetch.
  always_comb begin
    is_c    = (inst[1:0] != 2'b11);
    seq_pc  = pc_q + (is_c ? 32'd2 : 32'd4);
    pred_pc = seq_pc;
    stop    = 1'b0;
    if (!is_c) begin
      case (inst[6:0])
        7'b1101111: pred_pc = pc_q + imm_j;
        7'b1100011: if (inst[31]) pred_pc = pc_q + imm_b;
        7'b1100111: stop = 1'b1;
        default: ;
      endcase
    end else if (inst[1:0] == 2'b01) begin
      case (inst[15:13])
        3'b101, 3'b001: pred_pc = pc_q + imm_cj;
        3'b110, 3'b111: if (inst[12]) pred_pc = pc_q + imm_cb;
        default: ;
      endcase
    end else if (inst[1:0] == 2'b10 && inst[15:13] == 3'b100 &&
                 inst[11:7] != 5'd0 && inst[6:2] == 5'd0) begin
      stop = 1'b1;
    end
  end

  assign bus.fet_icache_enable = (state_q == FETCH) && !bus.iq_full && !bus.flush;
  assign accept = bus.fet_icache_enable && bus.icache_ready && !bus.stall;

  // flush > stall > accept; a stall simply falls through to hold.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push_d     = push_q;
    push_d.vld = 1'b0;
    if (bus.flush) begin
      pc_d    = bus.flush_pc;
      state_d = FETCH;
    end else if (accept) begin
      push_d = '{vld: 1'b1, inst: inst, pc: pc_q, is_c: is_c, pred_pc: pred_pc};
      pc_d   = pred_pc;
      if (stop) state_d = WAIT_REDIRECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      push_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      push_q  <= push_d;
    end
  end

  assign bus.fet_pc         = pc_q;
  assign bus.fet_iq_enable  = push_q.vld;
  assign bus.fet_iq_inst    = push_q.inst;
  assign bus.fet_iq_pc      = push_q.pc;
  assign bus.fet_iq_is_c    = push_q.is_c;
  assign bus.fet_iq_pred_pc = push_q.pred_pc;
endmodule

// File: tb/tb_fetcher.sv
// Directed scenarios plus randomized traffic against a behavioural fetch model.
module tb_fetcher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetcher_if bus();
  fetcher #(.RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  logic [31:0] m_pc, m_inst, m_ipc, m_pred;
  logic        m_wait, m_en, m_isc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic [31:0] fpc, input logic st,
                       input logic full, input logic rdy, input logic [31:0] inst);
    bus.flush = fl; bus.flush_pc = fpc; bus.stall = st;
    bus.iq_full = full; bus.icache_ready = rdy; bus.icache_inst = inst;
  endtask

  // Next-PC prediction computed from offset weights of the immediate bits.
  task automatic ref_pred(input logic [31:0] pc, input logic [31:0] i,
                          output logic [31:0] pred, output logic stop);
    int off;
    logic c;
    c = (i[1:0] != 2'b11);
    off = c ? 2 : 4;
    stop = 1'b0;
    if (!c && i[6:0] == 7'h6F)
      off = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096 - (i[31] ? 1 << 20 : 0);
    else if (!c && i[6:0] == 7'h63 && i[31])
      off = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048 - 4096;
    else if (!c && i[6:0] == 7'h67)
      stop = 1'b1;
    else if (i[1:0] == 2'b01 && (i[15:13] == 3'b101 || i[15:13] == 3'b001))
      off = int'(i[5:3]) * 2 + int'(i[11]) * 16 + int'(i[2]) * 32 + int'(i[7]) * 64 +
            int'(i[6]) * 128 + int'(i[10:9]) * 256 + int'(i[8]) * 1024 - (i[12] ? 2048 : 0);
    else if (i[1:0] == 2'b01 && i[15:14] == 2'b11 && i[12])
      off = int'(i[4:3]) * 2 + int'(i[11:10]) * 8 + int'(i[2]) * 32 + int'(i[6:5]) * 64 - 256;
    else if (i[1:0] == 2'b10 && i[15:13] == 3'b100 && i[11:7] != 5'd0 && i[6:2] == 5'd0)
      stop = 1'b1;
    pred = pc + 32'(off);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [2:0]  k;
    logic [4:0]  rs;
    r = $urandom;
    k = 3'($urandom_range(0, 7));
    rs = 5'($urandom_range(1, 31));
    case (k)
      3'd0: return {r[31:7], 7'h6F};
      3'd1: return {r[31:7], 7'h63};
      3'd2: return {r[31:7], 7'h67};
      3'd3: return {16'h0, r[20] ? 3'b101 : 3'b001, r[12:2], 2'b01};
      3'd4: return {16'h0, 2'b11, r[20], r[12:2], 2'b01};
      3'd5: return {16'h0, 3'b100, r[12], rs, 5'd0, 2'b10};
      3'd6: return {r[31:2], 2'b11};
      default: return {16'h0, r[15:2], (r[1:0] == 2'b11) ? 2'b00 : r[1:0]};
    endcase
  endfunction

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #12;
    n_tests++; if (bus.fet_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", bus.fet_pc); end
    n_tests++; if (bus.fet_iq_enable !== 1'b0) begin n_fail++; $display("FAIL rst_iq_en got %b exp 0", bus.fet_iq_enable); end
    n_tests++; if ({bus.fet_iq_inst, bus.fet_iq_pc, bus.fet_iq_pred_pc, bus.fet_iq_is_c} !== 97'h0) begin
      n_fail++; $display("FAIL rst_iq_fields got %h/%h/%h/%b exp 0", bus.fet_iq_inst, bus.fet_iq_pc, bus.fet_iq_pred_pc, bus.fet_iq_is_c); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00100093);
    #1;
    n_tests++; if (bus.fet_icache_enable !== 1'b1) begin n_fail++; $display("FAIL seq_enable got %b exp 1", bus.fet_icache_enable); end
    tick();
    n_tests++; if (bus.fet_iq_enable !== 1'b1 || bus.fet_iq_pc !== 32'h0 || bus.fet_iq_is_c !== 1'b0 || bus.fet_iq_pred_pc !== 32'h4) begin
      n_fail++; $display("FAIL seq_push32 got en=%b pc=%h c=%b pred=%h exp 1/0/0/4", bus.fet_iq_enable, bus.fet_iq_pc, bus.fet_iq_is_c, bus.fet_iq_pred_pc); end
    n_tests++; if (bus.fet_pc !== 32'h4) begin n_fail++; $display("FAIL seq_pc4 got %h exp 4", bus.fet_pc); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00000505);
    tick();
    n_tests++; if (bus.fet_iq_is_c !== 1'b1 || bus.fet_iq_pred_pc !== 32'h6 || bus.fet_iq_inst !== 32'h505) begin
      n_fail++; $display("FAIL seq_rvc got c=%b pred=%h inst=%h exp 1/6/505", bus.fet_iq_is_c, bus.fet_iq_pred_pc, bus.fet_iq_inst); end
    n_tests++; if (bus.fet_pc !== 32'h6) begin n_fail++; $display("FAIL seq_pc6 got %h exp 6", bus.fet_pc); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00100093);
    tick();
    n_tests++; if (bus.fet_pc !== 32'hA) begin n_fail++; $display("FAIL seq_pc10 got %h exp a", bus.fet_pc); end
  endtask

  task automatic test_branches();
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h0200006F);
    tick();
    n_tests++; if (bus.fet_pc !== 32'h10 || bus.fet_iq_enable !== 1'b0) begin
      n_fail++; $display("FAIL br_flush got pc=%h en=%b exp 10/0", bus.fet_pc, bus.fet_iq_enable); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0200006F);
    tick();
    n_tests++; if (bus.fet_iq_pred_pc !== 32'h30 || bus.fet_pc !== 32'h30) begin
      n_fail++; $display("FAIL br_jal got pred=%h pc=%h exp 30/30", bus.fet_iq_pred_pc, bus.fet_pc); end
    drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFE000CE3);
    tick();
    n_tests++; if (bus.fet_pc !== 32'h38) begin n_fail++; $display("FAIL br_back got %h exp 38", bus.fet_pc); end
    drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00000463);
    tick();
    n_tests++; if (bus.fet_pc !== 32'h44) begin n_fail++; $display("FAIL br_fwd got %h exp 44", bus.fet_pc); end
  endtask

  task automatic test_jalr();
    drive(1'b1, 32'h50, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00008067);
    tick();
    n_tests++; if (bus.fet_iq_enable !== 1'b1 || bus.fet_iq_pred_pc !== 32'h54 || bus.fet_pc !== 32'h54) begin
      n_fail++; $display("FAIL jalr_push got en=%b pred=%h pc=%h exp 1/54/54", bus.fet_iq_enable, bus.fet_iq_pred_pc, bus.fet_pc); end
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00100093);
      #1;
      n_tests++; if (bus.fet_icache_enable !== 1'b0) begin n_fail++; $display("FAIL jalr_wait_en cyc %0d got %b exp 0", c, bus.fet_icache_enable); end
      tick();
      n_tests++; if (bus.fet_iq_enable !== 1'b0 || bus.fet_pc !== 32'h54) begin
        n_fail++; $display("FAIL jalr_wait cyc %0d got en=%b pc=%h exp 0/54", c, bus.fet_iq_enable, bus.fet_pc); end
    end
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++; if (bus.fet_pc !== 32'h100 || bus.fet_icache_enable !== 1'b1) begin
      n_fail++; $display("FAIL jalr_redirect got pc=%h en=%b exp 100/1", bus.fet_pc, bus.fet_icache_enable); end
  endtask

  task automatic test_backpressure();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h00100093);
    #1;
    n_tests++; if (bus.fet_icache_enable !== 1'b0) begin n_fail++; $display("FAIL bp_full_en got %b exp 0", bus.fet_icache_enable); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (bus.fet_iq_enable !== 1'b0 || bus.fet_pc !== 32'h100) begin
        n_fail++; $display("FAIL bp_full cyc %0d got en=%b pc=%h exp 0/100", c, bus.fet_iq_enable, bus.fet_pc); end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h00100093);
    tick();
    n_tests++; if (bus.fet_iq_enable !== 1'b0 || bus.fet_pc !== 32'h100) begin
      n_fail++; $display("FAIL bp_stall got en=%b pc=%h exp 0/100", bus.fet_iq_enable, bus.fet_pc); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00100093);
    tick();
    n_tests++; if (bus.fet_iq_enable !== 1'b1 || bus.fet_iq_pc !== 32'h100 || bus.fet_pc !== 32'h104) begin
      n_fail++; $display("FAIL bp_release got en=%b ipc=%h pc=%h exp 1/100/104", bus.fet_iq_enable, bus.fet_iq_pc, bus.fet_pc); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h00100093);
    tick();
    n_tests++; if (bus.fet_iq_enable !== 1'b0) begin n_fail++; $display("FAIL bp_single_push got %b exp 0", bus.fet_iq_enable); end
  endtask

  task automatic test_flush_reset();
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 32'h00100093);
    tick();
    n_tests++; if (bus.fet_pc !== 32'h200 || bus.fet_iq_enable !== 1'b0) begin
      n_fail++; $display("FAIL fr_flush_wins got pc=%h en=%b exp 200/0", bus.fet_pc, bus.fet_iq_enable); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00100093);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.fet_pc !== 32'h0 || bus.fet_iq_enable !== 1'b0 || bus.fet_iq_pc !== 32'h0) begin
      n_fail++; $display("FAIL fr_async_rst got pc=%h en=%b ipc=%h exp 0/0/0", bus.fet_pc, bus.fet_iq_enable, bus.fet_iq_pc); end
    #1;
    rst_n = 1'b1;
    #1;
    n_tests++; if (bus.fet_icache_enable !== 1'b1 || bus.fet_pc !== 32'h0) begin
      n_fail++; $display("FAIL fr_release got en=%b pc=%h exp 1/0", bus.fet_icache_enable, bus.fet_pc); end
    tick();
    n_tests++; if (bus.fet_iq_enable !== 1'b1 || bus.fet_iq_pc !== 32'h0 || bus.fet_pc !== 32'h4) begin
      n_fail++; $display("FAIL fr_first_push got en=%b ipc=%h pc=%h exp 1/0/4", bus.fet_iq_enable, bus.fet_iq_pc, bus.fet_pc); end
  endtask

  task automatic test_random();
    logic fl, st, full, rdy, en_exp, stp;
    logic [31:0] fpc, inst, pr;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_pc = 32'h0; m_wait = 1'b0; m_en = 1'b0;
    m_inst = 32'h0; m_ipc = 32'h0; m_pred = 32'h0; m_isc = 1'b0;
    for (int c = 0; c < 600; c++) begin
      fl   = ($urandom_range(0, 99) < 8);
      st   = ($urandom_range(0, 99) < 15);
      full = ($urandom_range(0, 99) < 15);
      rdy  = ($urandom_range(0, 99) < 75);
      fpc  = $urandom;
      inst = rand_inst();
      drive(fl, fpc, st, full, rdy, inst);
      #1;
      en_exp = !m_wait && !full && !fl;
      n_tests++; if (bus.fet_icache_enable !== en_exp) begin
        n_fail++; $display("FAIL rnd_enable cyc %0d got %b exp %b", c, bus.fet_icache_enable, en_exp); end
      if (fl) begin
        m_pc = fpc; m_wait = 1'b0; m_en = 1'b0;
      end else if (en_exp && rdy && !st) begin
        ref_pred(m_pc, inst, pr, stp);
        m_en = 1'b1; m_inst = inst; m_ipc = m_pc; m_isc = (inst[1:0] != 2'b11);
        m_pred = pr; m_pc = pr; m_wait = stp;
      end else begin
        m_en = 1'b0;
      end
      tick();
      n_tests++; if (bus.fet_pc !== m_pc || bus.fet_iq_enable !== m_en) begin
        n_fail++; $display("FAIL rnd_pc cyc %0d got pc=%h en=%b exp %h/%b", c, bus.fet_pc, bus.fet_iq_enable, m_pc, m_en); end
      if (m_en) begin
        n_tests++;
        if (bus.fet_iq_inst !== m_inst || bus.fet_iq_pc !== m_ipc || bus.fet_iq_is_c !== m_isc || bus.fet_iq_pred_pc !== m_pred) begin
          n_fail++; $display("FAIL rnd_push cyc %0d got %h/%h/%b/%h exp %h/%h/%b/%h", c, bus.fet_iq_inst, bus.fet_iq_pc,
                             bus.fet_iq_is_c, bus.fet_iq_pred_pc, m_inst, m_ipc, m_isc, m_pred); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branches();
    test_jalr();
    test_backpressure();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
